magic_ctl: RTL and testbench
============================

# magic_ctl

Parametrised successor to the magic-mode controller, sitting between the CPU bus and the machine configuration fabric. It arbitrates NSRC NMI trigger sources into one NMI, records which source fired, and maps and unmaps the magic ROM. It also hosts a generic NREGS×8 configuration register bank with defaults, write strobes and optional readback on port xxFF.

## Interface
Parameters:
- NSRC, 4: number of NMI trigger sources, 1..8.
- NREGS, 16: configuration registers, 1..254; indices FE/FF are reserved.
- CFG_DEFAULTS, 0: NREGS*8-bit reset image; register i is bits [8i+7:8i].
- NMI_TIMEOUT, 4096: clk28 cycles n_nmi may stay low before abort.

Ports:
- clk28  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- bus  cpu_bus  -  memreq, ioreq, rd, wr, m1, a_reg[15:0], d_reg[7:0].
- n_int  in  1  current INT level.
- n_int_next  in  1  INT level next cycle.
- trig  in  NSRC  level triggers (buttons, watchdog, etc.).
- status  in  8  live status byte.
- n_nmi  out  1  NMI to CPU.
- magic_mode  out  1  magic session active.
- magic_map  out  1  magic ROM mapped.
- cfg  out  NREGS*8  register bank contents.
- cfg_wr  out  NREGS  one-cycle write strobe per register.
- d_out  out  8  read data.
- d_out_active  out  1  d_out drives the bus.

## Operation
- INT edge: n_int==1 && n_int_next==0.
- FSM states and transitions:
  - IDLE: on INT edge with any trig bit set → ARMED.
  - ARMED: next cycle → NMI. Sets n_nmi=0 and magic_mode=1. Loads cause[NSRC-1:0] |= trig.
  - NMI: fetch with m1 && memreq && a_reg==0066 → MAPPED, n_nmi=1, magic_map=1.
    - Timeout counter reaching NMI_TIMEOUT first → IDLE: n_nmi=1, magic_mode=0, cause[7]=1.
  - MAPPED: memreq && rd && a_reg==F000 → UNMAP, clears magic_mode. memreq && rd && a_reg==F008 → UNMAP with remap flag set.
  - UNMAP: first cycle with !memreq → magic_map=0. Goes to REMAP if the remap flag is set, otherwise to IDLE.
  - REMAP: next m1 && memreq at any address → MAPPED, magic_map=1.
- Triggers arriving in NMI/MAPPED/UNMAP/REMAP OR into cause only; no new NMI until IDLE.
- Port decode: config_cs = magic_map && ioreq && a_reg[7:0]==FF. High byte is the index.
- Writes (config_cs && wr):
  - index < NREGS: loads the register and pulses cfg_wr[i] for one cycle.
  - FE: clears the cause bits set in d_reg.
  - FF and out-of-range indices: ignored.
- Reads (config_cs && rd):
  - FF returns status.
  - FE returns cause.
  - Others per Configuration.
- A write and a clear of the same cause bit in one cycle: the set wins.

## Timing
- Reset values:
  - n_nmi=1, magic_mode=1, magic_map=1 (boot into magic ROM, state MAPPED).
  - cfg=CFG_DEFAULTS, cfg_wr=0, cause=0, d_out_active=0.
- n_nmi falls 2 cycles after the INT edge cycle.
- Timeout counter is cleared on entry to NMI and saturates.
- d_out_active and d_out are registered. They are valid the cycle after config_cs && rd and are held while rd persists.
- cfg updates the cycle after the wr cycle. For a multi-cycle wr, cfg_wr pulses once, on the first cycle only.
- Reset mid-session returns immediately to the mapped boot state.

## Configuration
- MAGIC_CFG_READBACK_EN defined: reads of index < NREGS return the register value.
- Undefined: those reads, and all other unreserved reads, leave d_out_active=0 (bus floats).

## Structure
- Package common:
  - magic_state_t enum (IDLE, ARMED, NMI, MAPPED, UNMAP, REMAP).
  - Constants MAGIC_ENTRY=16'h0066, MAGIC_EXIT=16'hF000, MAGIC_REEXIT=16'hF008, MAGIC_PORT=8'hFF, IDX_CAUSE=8'hFE, IDX_STATUS=8'hFF.
- Sub-module magic_cfg_bank: register array, default load, write strobes and readback mux. Parameters NREGS and CFG_DEFAULTS.

## Test plan
- After reset, read 0xF000 then bus idle → magic_map=0, magic_mode=0 one cycle after memreq drops.
- trig=4'b0010 held, INT edge → n_nmi=0 two cycles later. M1 fetch at 0066 → n_nmi=1, magic_map=1. IN from 0xFEFF → 0x02.
- NMI with no 0066 fetch for 4096 cycles → n_nmi=1, magic_mode=0, cause=0x80.
- While mapped, OUT 0x03FF,0x5A → cfg[31:24]=0x5A, cfg_wr[3] high for one cycle. IN 0x03FF → 0x5A with MAGIC_CFG_READBACK_EN, d_out_active=0 without it.
- Read 0xF008, memreq drops, next M1 at 0x8000 → magic_map 1→0→1, magic_mode stays 1.
- trig[0] during MAPPED → no NMI, cause[0]=1. OUT 0xFEFF,0x01 → cause=0.

Source files
------------

// File: rtl/magic_ctl_pkg.sv
// Shared types and decode constants for the magic-mode controller.
package magic_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    NMI,
    MAPPED,
    UNMAP,
    REMAP
  } magic_state_t;

  localparam logic [15:0] MAGIC_ENTRY  = 16'h0066;
  localparam logic [15:0] MAGIC_EXIT   = 16'hF000;
  localparam logic [15:0] MAGIC_REEXIT = 16'hF008;
  localparam logic [7:0]  MAGIC_PORT   = 8'hFF;
  localparam logic [7:0]  IDX_CAUSE    = 8'hFE;
  localparam logic [7:0]  IDX_STATUS   = 8'hFF;

endpackage

// File: rtl/magic_ctl_if.sv
// CPU bus as seen by the magic controller: the CPU drives, the controller observes.
interface cpu_bus;
  logic        memreq;
  logic        ioreq;
  logic        rd;
  logic        wr;
  logic        m1;
  logic [15:0] a_reg;
  logic [7:0]  d_reg;

  modport master (output memreq, ioreq, rd, wr, m1, a_reg, d_reg);
  modport slave  (input  memreq, ioreq, rd, wr, m1, a_reg, d_reg);
endinterface

// File: rtl/magic_ctl_cfg_bank.sv
// NREGS x 8 configuration register bank: reset image, per-register write strobes, readback mux.
module magic_cfg_bank #(
  parameter int                   NREGS        = 16,
  parameter logic [NREGS*8-1:0]   CFG_DEFAULTS = '0,
  parameter bit                   READBACK     = 1'b0
) (
  input  logic               clk28,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [7:0]         idx,
  input  logic [7:0]         wdata,
  output logic [NREGS*8-1:0] cfg,
  output logic [NREGS-1:0]   cfg_wr,
  output logic               rd_hit,
  output logic [7:0]         rd_data
);

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      cfg    <= CFG_DEFAULTS;
      cfg_wr <= '0;
    end else begin
      cfg_wr <= '0;
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en && idx == 8'(i)) begin
          cfg[8*i +: 8] <= wdata;
          cfg_wr[i]     <= 1'b1;
        end
      end
    end
  end

  // rd_hit stays low when readback is compiled out, so the bus floats for these indices.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx == 8'(i)) begin
        rd_hit  = READBACK;
        rd_data = cfg[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/magic_ctl.sv
// Magic-mode controller: NMI arbitration, cause capture, magic ROM map/unmap, config port xxFF.
// MAGIC_CFG_READBACK_EN enables readback of the config registers through the port.
module magic_ctl
  import magic_ctl_pkg::*;
#(
  parameter int                 NSRC         = 4,
  parameter int                 NREGS        = 16,
  parameter logic [NREGS*8-1:0] CFG_DEFAULTS = '0,
  parameter int                 NMI_TIMEOUT  = 4096
) (
  input  logic               clk28,
  input  logic               rst_n,
  cpu_bus.slave              bus,
  input  logic               n_int,
  input  logic               n_int_next,
  input  logic [NSRC-1:0]    trig,
  input  logic [7:0]         status,
  output logic               n_nmi,
  output logic               magic_mode,
  output logic               magic_map,
  output logic [NREGS*8-1:0] cfg,
  output logic [NREGS-1:0]   cfg_wr,
  output logic [7:0]         d_out,
  output logic               d_out_active
);

  localparam int CW = $clog2(NMI_TIMEOUT + 1);
`ifdef MAGIC_CFG_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  magic_state_t state, state_n;
  logic          nmi_n, mode_n, map_n, remap, remap_n, timeout;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    cause, cause_set, cause_clr, idx, rd_data, bank_data;
  logic          int_edge, config_cs, cs_wr_p1, wr_first, rd_hit, bank_hit;

  assign int_edge  = n_int && !n_int_next;
  assign idx       = bus.a_reg[15:8];
  assign config_cs = magic_map && bus.ioreq && (bus.a_reg[7:0] == MAGIC_PORT);
  assign wr_first  = config_cs && bus.wr && !cs_wr_p1;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MAPPED;
      n_nmi      <= 1'b1;
      magic_mode <= 1'b1;
      magic_map  <= 1'b1;
      remap      <= 1'b0;
      cnt        <= '0;
      cause      <= '0;
      cs_wr_p1   <= 1'b0;
    end else begin
      state      <= state_n;
      n_nmi      <= nmi_n;
      magic_mode <= mode_n;
      magic_map  <= map_n;
      remap      <= remap_n;
      cnt        <= cnt_n;
      cause      <= (cause & ~cause_clr) | cause_set;
      cs_wr_p1   <= config_cs && bus.wr;
    end
  end

  always_comb begin
    state_n = state;
    nmi_n   = n_nmi;
    mode_n  = magic_mode;
    map_n   = magic_map;
    remap_n = remap;
    cnt_n   = cnt;
    timeout = 1'b0;
    case (state)
      IDLE:   if (int_edge && |trig) state_n = ARMED;
      ARMED: begin
        state_n = NMI;
        nmi_n   = 1'b0;
        mode_n  = 1'b1;
        cnt_n   = '0;
      end
      NMI: begin
        if (bus.m1 && bus.memreq && bus.a_reg == MAGIC_ENTRY) begin
          state_n = MAPPED;
          nmi_n   = 1'b1;
          map_n   = 1'b1;
        end else if (cnt == CW'(NMI_TIMEOUT - 1)) begin
          state_n = IDLE;
          nmi_n   = 1'b1;
          mode_n  = 1'b0;
          timeout = 1'b1;
        end else if (cnt != {CW{1'b1}}) begin
          cnt_n = cnt + 1'b1;
        end
      end
      MAPPED: begin
        if (bus.memreq && bus.rd && bus.a_reg == MAGIC_EXIT) begin
          state_n = UNMAP;
          mode_n  = 1'b0;
          remap_n = 1'b0;
        end else if (bus.memreq && bus.rd && bus.a_reg == MAGIC_REEXIT) begin
          state_n = UNMAP;
          remap_n = 1'b1;
        end
      end
      UNMAP: begin
        if (!bus.memreq) begin
          map_n   = 1'b0;
          state_n = remap ? REMAP : IDLE;
        end
      end
      REMAP: begin
        if (bus.m1 && bus.memreq) begin
          state_n = MAPPED;
          map_n   = 1'b1;
        end
      end
      default: state_n = MAPPED;
    endcase
  end

  // Sources are only latched once an NMI is committed; set dominates a same-cycle clear.
  always_comb begin
    cause_set = '0;
    if (state != IDLE) begin
      for (int i = 0; i < NSRC; i++) cause_set[i] = trig[i];
    end
    if (timeout) cause_set[7] = 1'b1;
    cause_clr = (wr_first && idx == IDX_CAUSE) ? bus.d_reg : '0;
  end

  magic_cfg_bank #(
    .NREGS        (NREGS),
    .CFG_DEFAULTS (CFG_DEFAULTS),
    .READBACK     (READBACK)
  ) u_bank (
    .clk28   (clk28),
    .rst_n   (rst_n),
    .wr_en   (wr_first),
    .idx     (idx),
    .wdata   (bus.d_reg),
    .cfg     (cfg),
    .cfg_wr  (cfg_wr),
    .rd_hit  (bank_hit),
    .rd_data (bank_data)
  );

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    if (idx == IDX_STATUS) begin
      rd_hit  = 1'b1;
      rd_data = status;
    end else if (idx == IDX_CAUSE) begin
      rd_hit  = 1'b1;
      rd_data = cause;
    end else if (bank_hit) begin
      rd_hit  = 1'b1;
      rd_data = bank_data;
    end
  end

  // Read data is registered and refreshed every cycle the read persists.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) d_out_active <= 1'b0;
    else        d_out_active <= config_cs && bus.rd && rd_hit;
  end

  always_ff @(posedge clk28) begin
    if (config_cs && bus.rd) d_out <= rd_data;
  end

endmodule

// File: tb/tb_magic_ctl.sv
// Scoreboard bench for magic_ctl: directed bus sequences push expectations, a monitor compares.
module tb_magic_ctl;
  import magic_ctl_pkg::*;

  localparam int NSRC  = 4;
  localparam int NREGS = 16;
  localparam logic [NREGS*8-1:0] DEFS = 128'h0F0E0D0C_0B0A0908_07060504_A5020100;

  localparam logic [2:0] F_NMI = 3'd0, F_MODE = 3'd1, F_MAP = 3'd2,
                         F_CFG3 = 3'd3, F_CFGWR = 3'd4, F_ACT = 3'd5;

  typedef struct packed {
    logic [2:0]  f;
    logic [15:0] v;
  } snap_t;

  logic clk28 = 1'b0;
  logic rst_n;
  logic n_int, n_int_next;
  logic [NSRC-1:0] trig;
  logic [7:0] status;
  logic n_nmi, magic_mode, magic_map, d_out_active;
  logic [NREGS*8-1:0] cfg;
  logic [NREGS-1:0] cfg_wr;
  logic [7:0] d_out;

  cpu_bus bus_i ();

  magic_ctl #(
    .NSRC(NSRC), .NREGS(NREGS), .CFG_DEFAULTS(DEFS), .NMI_TIMEOUT(4096)
  ) dut (
    .clk28(clk28), .rst_n(rst_n), .bus(bus_i),
    .n_int(n_int), .n_int_next(n_int_next), .trig(trig), .status(status),
    .n_nmi(n_nmi), .magic_mode(magic_mode), .magic_map(magic_map),
    .cfg(cfg), .cfg_wr(cfg_wr), .d_out(d_out), .d_out_active(d_out_active)
  );

  always #5 clk28 = ~clk28;

  logic [7:0] rq[$];
  snap_t      sq[$];
  logic       snap_req = 1'b0;
  logic       act_prev = 1'b0;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sample(input logic [2:0] f);
    case (f)
      F_NMI:   return {15'b0, n_nmi};
      F_MODE:  return {15'b0, magic_mode};
      F_MAP:   return {15'b0, magic_map};
      F_CFG3:  return {8'b0, cfg[31:24]};
      F_CFGWR: return 16'(cfg_wr);
      default: return {15'b0, d_out_active};
    endcase
  endfunction

  function automatic string fname(input logic [2:0] f);
    case (f)
      F_NMI:   return "n_nmi";
      F_MODE:  return "magic_mode";
      F_MAP:   return "magic_map";
      F_CFG3:  return "cfg_reg3";
      F_CFGWR: return "cfg_wr";
      default: return "d_out_active";
    endcase
  endfunction

  // Monitor: read data is compared whenever the DUT starts driving the bus.
  always @(negedge clk28) begin
    snap_t s;
    if (d_out_active && !act_prev) begin
      if (rq.size() == 0) check("unexpected_read", {8'b0, d_out}, 16'hFFFF);
      else check("read_data", {8'b0, d_out}, {8'b0, rq.pop_front()});
    end
    act_prev = d_out_active;
    if (snap_req) begin
      if (sq.size() == 0) check("snap_underflow", 16'd1, 16'd0);
      else begin
        s = sq.pop_front();
        check(fname(s.f), sample(s.f), s.v);
      end
    end
  end

  task automatic step();
    @(posedge clk28);
    #1;
  endtask

  task automatic snap(input logic [2:0] f, input logic [15:0] v);
    sq.push_back('{f: f, v: v});
    snap_req = 1'b1;
    @(negedge clk28);
    #1 snap_req = 1'b0;
  endtask

  task automatic bus_set(input logic mreq, input logic ioreq, input logic rd, input logic wr,
                         input logic m1, input logic [15:0] a, input logic [7:0] d);
    bus_i.memreq = mreq; bus_i.ioreq = ioreq; bus_i.rd = rd; bus_i.wr = wr;
    bus_i.m1 = m1; bus_i.a_reg = a; bus_i.d_reg = d;
  endtask

  task automatic bus_idle();
    bus_set(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic port_rd(input logic [15:0] a, input logic [7:0] exp);
    rq.push_back(exp);
    step(); bus_set(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, a, 8'h00);
    step(); bus_idle();
    step();
  endtask

  task automatic port_wr(input logic [15:0] a, input logic [7:0] d);
    step(); bus_set(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a, d);
    step(); bus_idle();
    step();
  endtask

  task automatic mem_rd(input logic [15:0] a);
    step(); bus_set(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a, 8'h00);
  endtask

  task automatic int_edge(input logic [NSRC-1:0] t, input logic hold);
    step(); n_int_next = 1'b0; trig = t;
    step(); n_int_next = 1'b1; if (!hold) trig = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; n_int = 1'b1; n_int_next = 1'b1; trig = '0; status = 8'hC3;
    bus_idle();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    snap(F_NMI, 1); snap(F_MODE, 1); snap(F_MAP, 1);
    snap(F_CFG3, 16'h00A5); snap(F_CFGWR, 0); snap(F_ACT, 0);

    // Boot exit: F000 read, then bus idle unmaps.
    mem_rd(16'hF000);
    step(); bus_idle();
    snap(F_MAP, 1);
    step();
    snap(F_MAP, 0); snap(F_MODE, 0);

    // NMI from trig[1]: low two cycles after the INT edge, mapped by the 0066 fetch.
    int_edge(4'b0010, 1'b1);
    snap(F_NMI, 1);
    step();
    snap(F_NMI, 0); snap(F_MODE, 1);
    bus_set(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, MAGIC_ENTRY, 8'h00);
    step(); bus_idle(); trig = '0;
    snap(F_NMI, 1); snap(F_MAP, 1);
    port_rd(16'hFEFF, 8'h02);
    port_rd(16'hFFFF, 8'hC3);

    // Multi-cycle config write: single strobe, register updated.
    step(); bus_set(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h03FF, 8'h5A);
    step();
    snap(F_CFGWR, 16'h0008);
    step();
    snap(F_CFGWR, 0); snap(F_CFG3, 16'h005A);
    bus_idle();
`ifdef MAGIC_CFG_READBACK_EN
    port_rd(16'h03FF, 8'h5A);
`else
    step(); bus_set(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h03FF, 8'h00);
    step();
    snap(F_ACT, 0);
    bus_idle();
`endif

    // Trigger while mapped only records the cause.
    step(); trig = 4'b0001;
    step(); trig = '0;
    snap(F_NMI, 1);
    step(); step();
    snap(F_NMI, 1);
    port_rd(16'hFEFF, 8'h03);
    port_wr(16'hFEFF, 8'h01);
    port_rd(16'hFEFF, 8'h02);
    // Same-cycle set and clear of cause[0]: set wins.
    step(); trig = 4'b0001; bus_set(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFEFF, 8'h03);
    step(); trig = '0; bus_idle();
    port_rd(16'hFEFF, 8'h01);
    port_wr(16'hFEFF, 8'h01);
    port_rd(16'hFEFF, 8'h00);

    // F008 exit: unmap, then remap on the next M1 at any address.
    mem_rd(MAGIC_REEXIT);
    step(); bus_idle();
    snap(F_MAP, 1);
    step();
    snap(F_MAP, 0);
    bus_set(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000, 8'h00);
    step(); bus_idle();
    snap(F_MAP, 1); snap(F_MODE, 1);

    // Timeout with no 0066 fetch.
    mem_rd(MAGIC_EXIT);
    step(); bus_idle();
    step(); step();
    int_edge(4'b0100, 1'b0);
    step();
    snap(F_NMI, 0);
    repeat (4085) step();
    snap(F_NMI, 0);
    repeat (15) step();
    snap(F_NMI, 1); snap(F_MODE, 0);

    // Re-enter magic mode to read the timeout cause.
    int_edge(4'b0001, 1'b0);
    step(); step();
    bus_set(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, MAGIC_ENTRY, 8'h00);
    step(); bus_idle();
    port_rd(16'hFEFF, 8'h80);

    // Asynchronous reset from an unmapped session.
    mem_rd(MAGIC_EXIT);
    step(); bus_idle();
    step(); step();
    #3 rst_n = 1'b0;
    snap(F_MAP, 1); snap(F_MODE, 1); snap(F_CFG3, 16'h00A5);
    rst_n = 1'b1;

    repeat (5) step();
    check("read_queue_left", 16'(rq.size()), 16'd0);
    check("snap_queue_left", 16'(sq.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
